// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg
// Shared definitions for the instruction-memory program loader: loader state
// encoding, the default end-of-program marker and the instruction memory depth
// (also used by the instruction memory itself).
package imem_program_loader_pkg;

  localparam int          IMEM_WORDS        = 512;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/imem_program_loader_byte_word_packer.sv
// imem_program_loader_byte_word_packer
// Assembles a big-endian 32-bit word from four accepted bytes.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   clear_i      drops any partially assembled word (wins over byte_en_i)
//   byte_en_i    byte_i is accepted this cycle
//   byte_i       incoming byte
//   word_valid_o high in the cycle the fourth byte is accepted
//   word_o       assembled word, valid together with word_valid_o
module imem_program_loader_byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  // Only three bytes are stored; the fourth is taken straight from byte_i so
  // the FSM can register the full word on the same edge it is accepted.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_valid_o = byte_en_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader
// Loads a program into instruction memory from a byte stream while holding
// the CPU pipeline. Optionally zero-fills the memory first, then writes
// big-endian packed words at sequential addresses until a halt word, an abort
// or a full memory.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   i_load_start     start a load (honoured in IDLE/DONE only)
//   i_abort          end an in-progress load
//   i_byte(_valid)   byte stream; o_byte_ready accepts it
//   o_mem_we/waddr/wdata  instruction memory write port
//   o_mem_sel        loader owns the memory address mux
//   o_cpu_hold       stall to PC/IF during the load
//   o_load_done      high while in DONE
//   o_overflow       memory filled before the halt word arrived
//   o_word_count     words written from the stream, halt word included
//
// state | meaning
// IDLE  | no load since reset, fetch path owns memory
// CLEAR | zero-filling memory, one word per cycle
// RECV  | accepting bytes into the packer
// WRITE | one-cycle write of the assembled word
// DONE  | load finished, pipeline released
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int          ADDR_WORDS     = IMEM_WORDS,
  parameter int          AW             = $clog2(ADDR_WORDS),
  parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
  parameter bit          CLEAR_ON_START = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load_start,
  input  logic          i_abort,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_valid,
  output logic          o_byte_ready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_waddr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_mem_sel,
  output logic          o_cpu_hold,
  output logic          o_load_done,
  output logic          o_overflow,
  output logic [AW:0]   o_word_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDR_WORDS - 1);

  load_state_e   state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   word_count_q;
  logic          byte_ready_q, mem_we_q, mem_sel_q, cpu_hold_q;
  logic          load_done_q, overflow_q;

  logic          idle_or_done, active, start, abort, byte_en, word_valid;
  logic [31:0]   word;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign active       = (state_q == ST_CLEAR) || (state_q == ST_RECV) ||
                        (state_q == ST_WRITE);
  assign start        = i_load_start && idle_or_done;
  assign abort        = i_abort && active;
  // byte_ready_q is only ever set in RECV, so this is the accept handshake.
  assign byte_en      = i_byte_valid && byte_ready_q;

  // An abort also clears the packer, which drops a byte arriving with it.
  imem_program_loader_byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start || abort),
    .byte_en_i    (byte_en),
    .byte_i       (i_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= CLEAR_ON_START ? ST_CLEAR : ST_RECV;
            ptr_q        <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            load_done_q  <= 1'b0;
            cpu_hold_q   <= 1'b1;
            mem_sel_q    <= 1'b1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            mem_we_q     <= CLEAR_ON_START;
            byte_ready_q <= !CLEAR_ON_START;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            state_q     <= ST_DONE;
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
            mem_sel_q   <= 1'b0;
          end else if (waddr_q == LAST_ADDR) begin
            state_q      <= ST_RECV;
            mem_we_q     <= 1'b0;
            byte_ready_q <= 1'b1;
            ptr_q        <= '0;
          end else begin
            waddr_q <= waddr_q + AW'(1);
          end
        end
        ST_RECV: begin
          if (abort) begin
            state_q      <= ST_DONE;
            byte_ready_q <= 1'b0;
            load_done_q  <= 1'b1;
            cpu_hold_q   <= 1'b0;
            mem_sel_q    <= 1'b0;
          end else if (word_valid) begin
            state_q      <= ST_WRITE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b1;
            waddr_q      <= ptr_q;
            wdata_q      <= word;
          end
        end
        ST_WRITE: begin
          // The write in this cycle always completes, even under abort.
          mem_we_q     <= 1'b0;
          word_count_q <= word_count_q + (AW+1)'(1);
          if (abort || (wdata_q == HALT_WORD) || (ptr_q == LAST_ADDR)) begin
            state_q     <= ST_DONE;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
            mem_sel_q   <= 1'b0;
            overflow_q  <= !abort && (wdata_q != HALT_WORD);
          end else begin
            state_q      <= ST_RECV;
            ptr_q        <= ptr_q + AW'(1);
            byte_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_byte_ready = byte_ready_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_waddr  = waddr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_sel    = mem_sel_q;
  assign o_cpu_hold   = cpu_hold_q;
  assign o_load_done  = load_done_q;
  assign o_overflow   = overflow_q;
  assign o_word_count = word_count_q;

endmodule
